// File: rtl/mdu_iter_if.sv
// Pipeline-to-MDU connection: launch request and operands in, HI/LO and status out.
interface mdu_iter_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mf_req;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             dz;
  logic             stall;

  modport master (
    output start, op, a, b, mf_req, flush,
    input  hi, lo, busy, done, dz, stall
  );

  modport slave (
    input  start, op, a, b, mf_req, flush,
    output hi, lo, busy, done, dz, stall
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply,
// restoring divide on magnitudes, sign fix-up in a final cycle.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mdu_iter_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] acc_reg;   // product high half / partial remainder
  logic [WIDTH-1:0] qp_reg;    // multiplier bits / dividend-to-quotient bits
  logic [WIDTH-1:0] m_reg;     // |multiplicand| or |divisor|
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             is_div_reg, neg_q_reg, neg_r_reg, dz_pend_reg;
  logic             done_reg, dz_reg;

  logic             launch, is_signed;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign launch    = bus.start & ~bus.flush;
  assign is_signed = ~bus.op[0];
  assign a_abs     = (is_signed & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_abs     = (is_signed & bus.b[WIDTH-1]) ? -bus.b : bus.b;

  assign mul_sum  = {1'b0, acc_reg} + (qp_reg[0] ? {1'b0, m_reg} : '0);
  // Borrow out of the trial subtraction means the shifted remainder is below the divisor.
  assign div_diff = {1'b0, acc_reg, qp_reg[WIDTH-1]} - {2'b00, m_reg};
  assign div_ok   = ~div_diff[WIDTH+1];

  assign prod     = {acc_reg, qp_reg};
  assign prod_fix = neg_q_reg ? -prod : prod;
  assign quo_fix  = neg_q_reg ? -qp_reg : qp_reg;
  assign rem_fix  = neg_r_reg ? -acc_reg : acc_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (launch && !bus.op[2]) state_next = RUN;
      RUN: begin
        if (bus.flush)                  state_next = IDLE;
        else if (cnt_reg == CW'(1))     state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      qp_reg      <= '0;
      m_reg       <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      is_div_reg  <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      dz_pend_reg <= 1'b0;
      done_reg    <= 1'b0;
      dz_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      dz_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (launch && !bus.op[2]) begin
            is_div_reg  <= bus.op[1];
            acc_reg     <= '0;
            m_reg       <= bus.op[1] ? b_abs : a_abs;
            qp_reg      <= bus.op[1] ? a_abs : b_abs;
            neg_q_reg   <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r_reg   <= is_signed & bus.op[1] & bus.a[WIDTH-1];
            dz_pend_reg <= bus.op[1] & (bus.b == '0);
            cnt_reg     <= CW'(WIDTH);
          end else if (launch && bus.op == 3'b100) begin
            hi_reg <= bus.a;
          end else if (launch && bus.op == 3'b101) begin
            lo_reg <= bus.a;
          end
        end
        RUN: begin
          if (bus.flush) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
            if (is_div_reg) begin
              acc_reg <= div_ok ? div_diff[WIDTH-1:0] : {acc_reg[WIDTH-2:0], qp_reg[WIDTH-1]};
              qp_reg  <= {qp_reg[WIDTH-2:0], div_ok};
            end else begin
              acc_reg <= mul_sum[WIDTH:1];
              qp_reg  <= {mul_sum[0], qp_reg[WIDTH-1:1]};
            end
          end
        end
        FIN: begin
          cnt_reg <= '0;
          if (!bus.flush) begin
            done_reg <= 1'b1;
            dz_reg   <= dz_pend_reg;
            if (is_div_reg) begin
              // A zero divisor leaves |a| in the remainder, so the sign fix restores a itself.
              hi_reg <= rem_fix;
              lo_reg <= dz_pend_reg ? '1 : quo_fix;
            end else begin
              hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
              lo_reg <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;
  assign bus.busy  = (state_reg != IDLE);
  assign bus.done  = done_reg;
  assign bus.dz    = dz_reg;
  assign bus.stall = (state_reg != IDLE) & (bus.start | bus.mf_req);
endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; SHALL be even and >= 4.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock, all state changes on this edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  request to launch an operation or HI/LO move.
REQ-006 op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved.
REQ-007 a  in  WIDTH  multiplicand/dividend, or move data for MTHI/MTLO.
REQ-008 b  in  WIDTH  multiplier/divisor.
REQ-009 mf_req  in  1  ID-stage MFHI/MFLO wants hi/lo this cycle.
REQ-010 flush  in  1  abort the in-flight operation (branch/exception squash).
REQ-011 hi  out  WIDTH  HI register (high product / remainder).
REQ-012 lo  out  WIDTH  LO register (low product / quotient).
REQ-013 busy  out  1  iterative operation in flight.
REQ-014 done  out  1  one-cycle pulse, first cycle new hi/lo are visible.
REQ-015 dz  out  1  one-cycle pulse with done when a DIV/DIVU had b == 0.
REQ-016 stall  out  1  pipeline hold request to the PC and IF/ID registers.

Function
REQ-017 FSM states IDLE, RUN, FIN; busy SHALL be 1 exactly in RUN and FIN.
REQ-018 IDLE and start with op 000-011 (and no flush): latch operands, take absolute values for signed ops, record result signs, counter = WIDTH, go to RUN.
REQ-019 RUN: one radix-2 iteration per cycle (shift-add multiply, restoring divide); counter decrements; at counter 1 go to FIN.
REQ-020 FIN: apply sign correction, write hi/lo on the closing edge, set done (and dz if applicable) for the next cycle, return to IDLE.
REQ-021 Latency: start sampled on edge N -> hi/lo/done valid in cycle N+WIDTH+2; busy high for WIDTH+1 cycles.
REQ-022 MTHI/MTLO accepted only in IDLE: hi (resp. lo) <= a on the next edge; no busy, no done.
REQ-023 start while busy SHALL be ignored (no operand latch, no state change).
REQ-024 stall = busy & (start | mf_req); combinational; 0 in IDLE.
REQ-025 MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, two's complement for MULT.
REQ-026 DIV: quotient truncates toward zero; remainder has the dividend's sign; DIVU unsigned.
REQ-027 Signed overflow (a = most-negative, b = -1): lo = most-negative value, hi = 0, dz = 0.
REQ-028 Divide by zero: lo = all ones, hi = a unchanged, dz = 1 with done; latency unchanged.
REQ-029 flush in RUN or FIN: next state IDLE; hi/lo unchanged; no done/dz.
REQ-030 flush with start in IDLE: start ignored, including MTHI/MTLO.
REQ-031 Reserved op with start in IDLE: ignored, no state change.
REQ-032 done and dz SHALL be 0 in every cycle except the single cycle defined by REQ-020.

Reset
REQ-033 rst SHALL take precedence over start and flush in the same cycle.
REQ-034 On rst: state IDLE; counter 0; hi = lo = 0; busy = done = dz = stall = 0.
REQ-035 rst during RUN/FIN aborts the operation; no done is ever produced for it.

Verification (WIDTH = 32)
REQ-036 MULT a=0xFFFFFFFD (-3), b=5 -> busy 33 cycles; then done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-037 DIVU a=100, b=7 -> lo=14, hi=2; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-038 DIV a=0x12, b=0 -> done=1 and dz=1 together, lo=0xFFFFFFFF, hi=0x12; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, dz=0.
REQ-039 During MULT, start=1 and mf_req=1 -> stall=1 each cycle, second op ignored, first result correct.
REQ-040 MTHI a=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5 next cycle, lo unchanged; flush at RUN cycle 10 of a DIVU -> busy=0 next cycle, hi/lo unchanged, no done.
REQ-041 rst asserted mid-DIV -> next cycle hi=lo=0, busy=0, no done thereafter.
